// File: rtl/cp0_exc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cp0_exc_ctrl
// Brief    : CP0 exception/interrupt controller (SR/Cause/EPC/PRId) at M stage
// Revision : 1.0 - initial release
// ============================================================================
module cp0_exc_ctrl #(
  parameter int          HWINT_W    = 6,
  parameter logic [31:0] PRID_VALUE = 32'h2023_0007
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               M_cp0We,
  input  logic [4:0]         M_cp0Addr,
  input  logic [31:0]        M_cp0WData,
  input  logic [31:0]        M_PC,
  input  logic               M_isBD,
  input  logic [4:0]         M_excCode,
  input  logic               M_isEret,
  input  logic [HWINT_W-1:0] HWInt,
  output logic [31:0]        cp0RData,
  output logic [31:0]        EPC_out,
  output logic               intReq
);

  localparam logic [4:0] c_ADDR_SR    = 5'd12;
  localparam logic [4:0] c_ADDR_CAUSE = 5'd13;
  localparam logic [4:0] c_ADDR_EPC   = 5'd14;
  localparam logic [4:0] c_ADDR_PRID  = 5'd15;

  logic [HWINT_W-1:0] r_im;
  logic [HWINT_W-1:0] r_ip;
  logic               r_exl;
  logic               r_ie;
  logic               r_bd;
  logic [4:0]         r_excCode;
  logic [31:0]        r_epc;

  logic               w_irq;
  logic               w_exc;
  logic               w_intReq;
  logic [31:0]        w_sr;
  logic [31:0]        w_cause;
  logic               w_unused;

  assign w_irq    = r_ie & ~r_exl & (|(HWInt & r_im));
  assign w_exc    = ~r_exl & (M_excCode != 5'd0);
  // Gated by reset so the request falls the moment reset asserts
  assign w_intReq = reset & (w_irq | w_exc);
  assign intReq   = w_intReq;
  assign EPC_out  = r_epc;

  assign w_unused = ^{M_cp0WData[31:16], M_cp0WData[9:2]};

  always_comb begin
    w_sr                  = 32'd0;
    w_sr[10 +: HWINT_W]   = r_im;
    w_sr[1]               = r_exl;
    w_sr[0]               = r_ie;
    w_cause               = 32'd0;
    w_cause[31]           = r_bd;
    w_cause[10 +: HWINT_W] = r_ip;
    w_cause[6:2]          = r_excCode;
  end

  always_comb begin
    case (M_cp0Addr)
      c_ADDR_SR:    cp0RData = w_sr;
      c_ADDR_CAUSE: cp0RData = w_cause;
      c_ADDR_EPC:   cp0RData = r_epc;
      c_ADDR_PRID:  cp0RData = PRID_VALUE;
      default:      cp0RData = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_im      <= '0;
      r_ip      <= '0;
      r_exl     <= 1'b0;
      r_ie      <= 1'b0;
      r_bd      <= 1'b0;
      r_excCode <= 5'd0;
      r_epc     <= 32'd0;
    end else begin
      r_ip <= HWInt;
      if (w_intReq) begin
        // The victim never completes, so its mtc0/eret side effects are dropped
        r_exl     <= 1'b1;
        r_excCode <= w_irq ? 5'd0 : M_excCode;
        r_bd      <= M_isBD;
        r_epc     <= M_isBD ? (M_PC - 32'd4) : M_PC;
      end else begin
        if (M_isEret) begin
          r_exl <= 1'b0;
        end
        if (M_cp0We) begin
          if (M_cp0Addr == c_ADDR_SR) begin
            r_im  <= M_cp0WData[10 +: HWINT_W];
            r_exl <= M_cp0WData[1];
            r_ie  <= M_cp0WData[0];
          end else if (M_cp0Addr == c_ADDR_EPC) begin
            r_epc <= M_cp0WData;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cp0_exc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cp0_exc_ctrl
// Brief    : Self-checking bench for cp0_exc_ctrl, word-level reference model
// Revision : 1.0 - initial release
// ============================================================================
module tb_cp0_exc_ctrl;

  localparam logic [31:0] c_PRID   = 32'h2023_0007;
  localparam logic [31:0] c_SRMASK = 32'h0000_FC03;

  logic        clk = 1'b0;
  logic        reset;
  logic        M_cp0We;
  logic [4:0]  M_cp0Addr;
  logic [31:0] M_cp0WData;
  logic [31:0] M_PC;
  logic        M_isBD;
  logic [4:0]  M_excCode;
  logic        M_isEret;
  logic [5:0]  HWInt;
  logic [31:0] cp0RData;
  logic [31:0] EPC_out;
  logic        intReq;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  // Architectural register words of the reference model
  logic [31:0] m_sr    = 32'd0;
  logic [31:0] m_cause = 32'd0;
  logic [31:0] m_epc   = 32'd0;

  cp0_exc_ctrl #(.HWINT_W(6), .PRID_VALUE(c_PRID)) dut (
    .clk        (clk),
    .reset      (reset),
    .M_cp0We    (M_cp0We),
    .M_cp0Addr  (M_cp0Addr),
    .M_cp0WData (M_cp0WData),
    .M_PC       (M_PC),
    .M_isBD     (M_isBD),
    .M_excCode  (M_excCode),
    .M_isEret   (M_isEret),
    .HWInt      (HWInt),
    .cp0RData   (cp0RData),
    .EPC_out    (EPC_out),
    .intReq     (intReq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_irq();
    logic [5:0] im;
    im = m_sr[15:10];
    return m_sr[0] && !m_sr[1] && ((HWInt & im) != 6'd0);
  endfunction

  function automatic logic model_req();
    if (!reset) return 1'b0;
    return model_irq() || (!m_sr[1] && M_excCode != 5'd0);
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return c_PRID;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_sr = 32'd0; m_cause = 32'd0; m_epc = 32'd0;
    end else if (model_req()) begin
      m_cause = ({31'd0, M_isBD} << 31) | ({26'd0, HWInt} << 10)
              | ({27'd0, (model_irq() ? 5'd0 : M_excCode)} << 2);
      m_epc   = M_isBD ? M_PC - 32'd4 : M_PC;
      m_sr    = m_sr | 32'd2;
    end else begin
      m_cause = (m_cause & ~32'h0000_FC00) | ({26'd0, HWInt} << 10);
      if (M_isEret) m_sr = m_sr & ~32'd2;
      if (M_cp0We && M_cp0Addr == 5'd12) m_sr = M_cp0WData & c_SRMASK;
      if (M_cp0We && M_cp0Addr == 5'd14) m_epc = M_cp0WData;
    end
  end

  // Compare process: inputs are stable at the falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("intReq", {31'd0, intReq}, {31'd0, model_req()});
      check("cp0RData", cp0RData, model_read(M_cp0Addr));
      check("EPC_out", EPC_out, m_epc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    M_cp0We = 0; M_cp0Addr = 5'd0; M_cp0WData = 32'd0; M_PC = 32'd0;
    M_isBD = 0; M_excCode = 5'd0; M_isEret = 0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    M_cp0We = 1; M_cp0Addr = a; M_cp0WData = d;
  endtask

  initial begin
    idle();
    reset = 0; HWInt = 6'h3F; M_excCode = 5'd4;
    chk_en = 1'b1;
    #2;
    check("rst_intReq", {31'd0, intReq}, 32'd0);
    M_cp0Addr = 5'd12; #1 check("rst_sr", cp0RData, 32'd0);
    M_cp0Addr = 5'd13; #1 check("rst_cause", cp0RData, 32'd0);
    M_cp0Addr = 5'd14; #1 check("rst_epc", cp0RData, 32'd0);
    step(); step();
    idle(); HWInt = 6'd0; reset = 1;

    // SR write is masked; EXL=1 holds off the interrupt
    step(); mtc0(5'd12, 32'hFFFF_FFFF);
    step(); idle(); HWInt = 6'd1; M_cp0Addr = 5'd12; #2;
    check("sr_masked", cp0RData, 32'h0000_FC03);
    check("exl_masks", {31'd0, intReq}, 32'd0);
    step(); mtc0(5'd12, 32'h0000_0401);
    step(); idle(); M_PC = 32'h0000_3000; #2;
    check("irq_fire", {31'd0, intReq}, 32'd1);
    step(); idle(); M_cp0Addr = 5'd13; #2;
    check("irq_cause", cp0RData, 32'h0000_0400);
    check("irq_epc", EPC_out, 32'h0000_3000);

    // Overflow in a delay slot
    step(); HWInt = 6'd0; mtc0(5'd12, 32'h0000_0001);
    step(); idle(); M_excCode = 5'd12; M_isBD = 1; M_PC = 32'h0000_3010; #2;
    check("bd_fire", {31'd0, intReq}, 32'd1);
    step(); M_cp0Addr = 5'd13; #2;
    check("bd_masked", {31'd0, intReq}, 32'd0);
    check("bd_epc", EPC_out, 32'h0000_300C);
    check("bd_cause", cp0RData, 32'h8000_0030);

    // Interrupt beats exception; same-cycle mtc0 EPC is discarded
    step(); idle(); mtc0(5'd12, 32'h0000_0401);
    step(); idle(); HWInt = 6'd1; M_excCode = 5'd4; M_PC = 32'h0000_4000;
    mtc0(5'd14, 32'hDEAD_BEEF); #2;
    check("both_fire", {31'd0, intReq}, 32'd1);
    step(); idle(); M_cp0Addr = 5'd13; #2;
    check("both_cause", cp0RData, 32'h0000_0400);
    check("both_epc", EPC_out, 32'h0000_4000);

    // eret with interrupt still pending re-fires after EXL clears
    step(); idle(); M_isEret = 1; #2;
    check("eret_hold", {31'd0, intReq}, 32'd0);
    step(); idle(); #2;
    check("eret_refire", {31'd0, intReq}, 32'd1);

    // Bubble is harmless; EPC wraps below zero
    step(); idle(); HWInt = 6'd0; mtc0(5'd12, 32'h0000_0001);
    step(); idle(); #2;
    check("bubble", {31'd0, intReq}, 32'd0);
    step(); idle(); M_isBD = 1; M_excCode = 5'd4; #2;
    check("wrap_fire", {31'd0, intReq}, 32'd1);
    step(); idle(); M_cp0Addr = 5'd15; #2;
    check("wrap_epc", EPC_out, 32'hFFFF_FFFC);
    check("prid", cp0RData, c_PRID);
    M_cp0Addr = 5'd7; #1;
    check("rd_other", cp0RData, 32'd0);

    // Randomized traffic including mid-run resets
    for (int i = 0; i < 3000; i++) begin
      step();
      reset      = ($urandom_range(0, 99) >= 2);
      HWInt      = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
      M_excCode  = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'd0;
      M_PC       = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      M_isBD     = 1'($urandom);
      M_isEret   = ($urandom_range(0, 5) == 0);
      M_cp0We    = !M_isEret && ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 4))
        0: M_cp0Addr = 5'd12;
        1: M_cp0Addr = 5'd13;
        2: M_cp0Addr = 5'd14;
        3: M_cp0Addr = 5'd15;
        default: M_cp0Addr = 5'($urandom);
      endcase
      M_cp0WData = $urandom | {31'd0, ($urandom_range(0, 1) == 1)};
      if (M_cp0We && M_cp0Addr == 5'd12 && $urandom_range(0, 1) == 1)
        M_cp0WData = M_cp0WData & ~32'd2;
    end

    step();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
